// File: rtl/cache_axi_arbiter_if.sv
// Bundle of cache-side and bus-side AXI3 channels shared by the arbiter.
// The arbiter takes the master modport; the caches and bus bridge take the slave modport.
interface cache_axi_arbiter_if;
  logic [31:0] i_araddr;
  logic [3:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic        i_arvalid, i_arready;
  logic [31:0] i_rdata;
  logic        i_rlast, i_rvalid, i_rready;

  logic [31:0] d_araddr;
  logic [3:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic        d_arvalid, d_arready;
  logic [31:0] d_rdata;
  logic        d_rlast, d_rvalid, d_rready;

  logic [31:0] d_awaddr;
  logic [3:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic        d_awvalid, d_awready;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wlast, d_wvalid, d_wready;
  logic        d_bvalid, d_bready;

  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic        m_rlast, m_rvalid, m_rready;

  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;

  modport master (
    input  i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
    output i_arready, i_rdata, i_rlast, i_rvalid,
    input  d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    output d_arready, d_rdata, d_rlast, d_rvalid,
    input  d_awaddr, d_awlen, d_awsize, d_awvalid,
    output d_awready,
    input  d_wdata, d_wstrb, d_wlast, d_wvalid,
    output d_wready,
    output d_bvalid,
    input  d_bready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rlast, m_rvalid,
    output m_rready,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bvalid,
    output m_bready
  );

  modport slave (
    output i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
    input  i_arready, i_rdata, i_rlast, i_rvalid,
    output d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    input  d_arready, d_rdata, d_rlast, d_rvalid,
    output d_awaddr, d_awlen, d_awsize, d_awvalid,
    input  d_awready,
    output d_wdata, d_wstrb, d_wlast, d_wvalid,
    input  d_wready,
    input  d_bvalid,
    output d_bready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arvalid,
    output m_arready,
    output m_rdata, m_rlast, m_rvalid,
    input  m_rready,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI3 burst master port between the I-cache (read) and D-cache (read/write).
// One read burst and one write burst in flight at most; the two paths run independently.
module cache_axi_arbiter #(
  parameter bit         RR_EN = 1'b1,
  parameter logic [3:0] ID_I  = 4'd0,
  parameter logic [3:0] ID_D  = 4'd1
) (
  input logic                 clk,
  input logic                 rst,
  cache_axi_arbiter_if.master bus
);
  localparam int unsigned LINE_W = 27;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {R_IDLE, R_AR_I, R_AR_D, R_DATA_I, R_DATA_D} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

  rd_state_e rd_state, rd_next;
  wr_state_e wr_state, wr_next;

  logic              last_grant_d;  // 1: previous read burst went to the D-cache
  logic [LINE_W-1:0] aw_line;
  logic [CNT_W-1:0]  aw_len;
  logic [CNT_W-1:0]  beat_cnt;
  logic              wr_err;

  logic hazard_c, i_req_c, d_win_c, r_done_c, aw_hs_c, w_hs_c, b_hs_c;

  // Grant decision and handshake qualifiers, all gated by the owning state
  always_comb begin
    hazard_c = (wr_state != W_IDLE) && (bus.i_araddr[31:5] == aw_line);
    i_req_c  = bus.i_arvalid && !hazard_c;
    d_win_c  = bus.d_arvalid && (!i_req_c || !RR_EN || !last_grant_d);
    r_done_c = bus.m_rvalid && bus.m_rlast &&
               (((rd_state == R_DATA_I) && bus.i_rready) ||
                ((rd_state == R_DATA_D) && bus.d_rready));
    aw_hs_c  = (wr_state == W_ADDR) && bus.d_awvalid && bus.m_awready;
    w_hs_c   = (wr_state == W_DATA) && bus.d_wvalid && bus.m_wready;
    b_hs_c   = (wr_state == W_RESP) && bus.m_bvalid && bus.d_bready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // Grant history, latched write line/length and the write beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d <= 1'b0;
      aw_line      <= '0;
      aw_len       <= '0;
      beat_cnt     <= '0;
      wr_err       <= 1'b0;
    end else begin
      if (r_done_c) last_grant_d <= (rd_state == R_DATA_D);
      if ((wr_state == W_IDLE) && bus.d_awvalid) begin
        aw_line <= bus.d_awaddr[31:5];
        aw_len  <= bus.d_awlen;
      end
      if (w_hs_c) begin
        beat_cnt <= bus.d_wlast ? '0 : beat_cnt + CNT_W'(1);
        if (bus.d_wlast && (beat_cnt != aw_len)) wr_err <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    wr_next = wr_state;
    case (rd_state)
      R_IDLE:   if (d_win_c) rd_next = R_AR_D;
                else if (i_req_c) rd_next = R_AR_I;
      R_AR_I:   if (bus.m_arready) rd_next = R_DATA_I;
      R_AR_D:   if (bus.m_arready) rd_next = R_DATA_D;
      R_DATA_I,
      R_DATA_D: if (r_done_c) rd_next = R_IDLE;
      default:  rd_next = R_IDLE;
    endcase
    case (wr_state)
      W_IDLE:  if (bus.d_awvalid) wr_next = W_ADDR;
      W_ADDR:  if (aw_hs_c) wr_next = W_DATA;
      W_DATA:  if (w_hs_c && bus.d_wlast) wr_next = W_RESP;
      W_RESP:  if (b_hs_c) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Channel steering; every valid/ready is 0 outside its owning state
  always_comb begin
    bus.m_arid    = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arsize  = '0;
    bus.m_arvalid = 1'b0;
    bus.i_arready = 1'b0;
    bus.d_arready = 1'b0;
    bus.m_rready  = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rlast   = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rlast   = 1'b0;
    bus.i_rdata   = bus.m_rdata;
    bus.d_rdata   = bus.m_rdata;
    bus.m_awid    = '0;
    bus.m_awaddr  = '0;
    bus.m_awlen   = '0;
    bus.m_awsize  = '0;
    bus.m_awvalid = 1'b0;
    bus.d_awready = 1'b0;
    bus.m_wdata   = '0;
    bus.m_wstrb   = '0;
    bus.m_wlast   = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.d_wready  = 1'b0;
    bus.d_bvalid  = 1'b0;
    bus.m_bready  = 1'b0;
    case (rd_state)
      R_AR_I: begin
        bus.m_arid    = ID_I;
        bus.m_araddr  = bus.i_araddr;
        bus.m_arlen   = bus.i_arlen;
        bus.m_arsize  = bus.i_arsize;
        bus.m_arvalid = 1'b1;
        bus.i_arready = bus.m_arready;
      end
      R_AR_D: begin
        bus.m_arid    = ID_D;
        bus.m_araddr  = bus.d_araddr;
        bus.m_arlen   = bus.d_arlen;
        bus.m_arsize  = bus.d_arsize;
        bus.m_arvalid = 1'b1;
        bus.d_arready = bus.m_arready;
      end
      R_DATA_I: begin
        bus.m_rready = bus.i_rready;
        bus.i_rvalid = bus.m_rvalid;
        bus.i_rlast  = bus.m_rlast;
      end
      R_DATA_D: begin
        bus.m_rready = bus.d_rready;
        bus.d_rvalid = bus.m_rvalid;
        bus.d_rlast  = bus.m_rlast;
      end
      default: ;
    endcase
    case (wr_state)
      W_ADDR: begin
        bus.m_awid    = ID_D;
        bus.m_awaddr  = bus.d_awaddr;
        bus.m_awlen   = bus.d_awlen;
        bus.m_awsize  = bus.d_awsize;
        bus.m_awvalid = bus.d_awvalid;
        bus.d_awready = bus.m_awready;
      end
      W_DATA: begin
        bus.m_wdata  = bus.d_wdata;
        bus.m_wstrb  = bus.d_wstrb;
        bus.m_wlast  = bus.d_wlast;
        bus.m_wvalid = bus.d_wvalid;
        bus.d_wready = bus.m_wready;
      end
      W_RESP: begin
        bus.d_bvalid = bus.m_bvalid;
        bus.m_bready = bus.d_bready;
      end
      default: ;
    endcase
  end

  // Write burst length must match the announced awlen
  wr_len_ok: assert property (@(posedge clk) disable iff (rst) !wr_err);
endmodule
